mpe_feeder: RTL and testbench

//  Drives the NUMBER_PE x 1 MPE column (the producer side of its weight/fmap interface).

---
 rtl/mpe_pkg.sv | 24 ++
 rtl/mpe_skew_line.sv | 51 +++++
 rtl/mpe_feeder.sv | 157 +++++++++++++++
 tb/tb_mpe_feeder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpe_pkg.sv
// rtl/mpe_pkg.sv - shared defaults, FSM state type and counter sizing for the MPE feeder
// Contents:
//   MPE_DATA_WIDTH  default word width (IEEE-754 single)
//   MPE_NUMBER_PE   default column height (lanes / weight words per pass)
//   mpe_state_e     feeder FSM states
//   cnt_width()     counter width able to hold 0..n without wrapping
package mpe_pkg;

  localparam int MPE_DATA_WIDTH = 32;
  localparam int MPE_NUMBER_PE  = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } mpe_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mpe_skew_line.sv
// rtl/mpe_skew_line.sv - valid+data delay line feeding one MPE lane
// Ports:
//   clk        in   1           clock, rising edge
//   rst_n      in   1           async reset, active-low
//   in_valid   in   1           slot valid entering the line
//   in_data    in   DATA_WIDTH  slot data entering the line
//   out_valid  out  1           valid after DELAY+1 register stages
//   out_data   out  DATA_WIDTH  data after DELAY+1 stages; holds across bubbles
module mpe_skew_line
  import mpe_pkg::*;
#(
  parameter int DATA_WIDTH = MPE_DATA_WIDTH,
  parameter int DELAY      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DELAY:0]        vld_q;
  logic [DATA_WIDTH-1:0] dat_q [DELAY+1];

  // Data stages only load behind a valid slot, so a bubble leaves the
  // previous word parked in every stage it passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i <= DELAY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        dat_q[0] <= in_data;
      end
      for (int i = 1; i <= DELAY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[DELAY];
  assign out_data  = dat_q[DELAY];

endmodule

// File: rtl/mpe_feeder.sv
// rtl/mpe_feeder.sv - producer side of the NUMBER_PE x 1 MPE column: weight load then skewed fmap stream
// Ports:
//   i_clk, i_rest_n                   clock / async active-low reset
//   i_start                           begin a pass (IDLE only)
//   i_w_valid, i_w_data, o_w_ready    weight words, k-th accepted -> lane k
//   i_f_valid, i_f_data, i_f_last,
//   o_f_ready                         fmap column vectors, slice k -> lane k
//   o_weight_en, o_weight_f_top       weight bank to MPE
//   o_left_en, o_right_en,
//   o_fmap_f_left                     diagonally skewed fmap lanes to MPE
//   o_busy, o_done                    pass status
module mpe_feeder
  import mpe_pkg::*;
#(
  parameter int DATA_WIDTH = MPE_DATA_WIDTH,
  parameter int NUMBER_PE  = MPE_NUMBER_PE
) (
  input  logic                            i_clk,
  input  logic                            i_rest_n,
  input  logic                            i_start,
  input  logic                            i_w_valid,
  input  logic [DATA_WIDTH-1:0]           i_w_data,
  output logic                            o_w_ready,
  input  logic                            i_f_valid,
  input  logic [NUMBER_PE*DATA_WIDTH-1:0] i_f_data,
  input  logic                            i_f_last,
  output logic                            o_f_ready,
  output logic                            o_weight_en,
  output logic [NUMBER_PE*DATA_WIDTH-1:0] o_weight_f_top,
  output logic [NUMBER_PE-1:0]            o_left_en,
  output logic [NUMBER_PE-1:0]            o_right_en,
  output logic [NUMBER_PE*DATA_WIDTH-1:0] o_fmap_f_left,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int             CNT_W    = cnt_width(NUMBER_PE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMBER_PE - 1);

  mpe_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                w_cnt_q;
  logic [CNT_W-1:0]                drain_cnt_q;
  logic                            weight_en_q;
  logic [NUMBER_PE*DATA_WIDTH-1:0] weight_q;
  logic                            w_acc;
  logic                            f_acc;

  // Handshakes decoded from state directly so the ready outputs never feed
  // back into the next-state logic.
  assign w_acc = i_w_valid && (state_q == LOAD_W);
  assign f_acc = i_f_valid && (state_q == STREAM);

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_w_ready = 1'b0;
    o_f_ready = 1'b0;
    o_done    = 1'b0;
    o_busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD_W;
      end
      LOAD_W: begin
        o_w_ready = 1'b1;
        if (i_w_valid && (w_cnt_q == LAST_IDX)) state_d = STREAM;
      end
      STREAM: begin
        o_f_ready = 1'b1;
        if (i_f_valid && i_f_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters are one bit wider than the lane index so w_cnt can reach
  // NUMBER_PE after the final accept without wrapping.
  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      w_cnt_q     <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        w_cnt_q <= '0;
      end else if (w_acc) begin
        w_cnt_q <= w_cnt_q + 1'b1;
      end

      // Loaded so the last vector reaches the far lane before DONE.
      if (f_acc && i_f_last) begin
        drain_cnt_q <= LAST_IDX;
      end else if ((state_q == DRAIN) && (drain_cnt_q != '0)) begin
        drain_cnt_q <= drain_cnt_q - 1'b1;
      end
    end
  end

  // weight_en rises the edge after the bank is complete (first STREAM edge)
  // and drops as the pass enters DONE.
  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      weight_en_q <= 1'b0;
    end else if (state_q == STREAM) begin
      weight_en_q <= 1'b1;
    end else if (state_d == DONE) begin
      weight_en_q <= 1'b0;
    end
  end

  // Weight bank keeps its contents until overwritten in the next LOAD_W.
  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      weight_q <= '0;
    end else begin
      for (int k = 0; k < NUMBER_PE; k++) begin
        if (w_acc && (w_cnt_q == CNT_W'(k))) begin
          weight_q[k*DATA_WIDTH +: DATA_WIDTH] <= i_w_data;
        end
      end
    end
  end

  assign o_weight_en    = weight_en_q;
  assign o_weight_f_top = weight_q;

  // Lane k sits k stages deeper than lane 0 to build the diagonal wavefront.
  for (genvar k = 0; k < NUMBER_PE; k++) begin : g_lane
    mpe_skew_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DELAY      (k)
    ) u_skew (
      .clk       (i_clk),
      .rst_n     (i_rest_n),
      .in_valid  (f_acc),
      .in_data   (i_f_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (o_left_en[k]),
      .out_data  (o_fmap_f_left[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign o_right_en = o_left_en;

endmodule

// File: tb/tb_mpe_feeder.sv
// tb/tb_mpe_feeder.sv - scoreboard bench for mpe_feeder
module tb_mpe_feeder;

  localparam int DW  = 32;
  localparam int NPE = 9;
  localparam int VW  = DW * NPE;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic          i_w_valid;
  logic [DW-1:0] i_w_data;
  logic          o_w_ready;
  logic          i_f_valid;
  logic [VW-1:0] i_f_data;
  logic          i_f_last;
  logic          o_f_ready;
  logic          o_weight_en;
  logic [VW-1:0] o_weight_f_top;
  logic [NPE-1:0] o_left_en;
  logic [NPE-1:0] o_right_en;
  logic [VW-1:0] o_fmap_f_left;
  logic          o_busy;
  logic          o_done;

  mpe_feeder #(.DATA_WIDTH(DW), .NUMBER_PE(NPE)) dut (
    .i_clk          (clk),
    .i_rest_n       (rst_n),
    .i_start        (i_start),
    .i_w_valid      (i_w_valid),
    .i_w_data       (i_w_data),
    .o_w_ready      (o_w_ready),
    .i_f_valid      (i_f_valid),
    .i_f_data       (i_f_data),
    .i_f_last       (i_f_last),
    .o_f_ready      (o_f_ready),
    .o_weight_en    (o_weight_en),
    .o_weight_f_top (o_weight_f_top),
    .o_left_en      (o_left_en),
    .o_right_en     (o_right_en),
    .o_fmap_f_left  (o_fmap_f_left),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: per-lane {cycle, data} expectations and expected done cycles.
  logic [63:0]   lane_q [NPE][$];
  int            done_q [$];
  logic [DW-1:0] last_dat [NPE];
  bit            mon_on = 1'b0;

  always @(negedge clk) begin
    logic exp_en;
    if (mon_on) begin
      for (int k = 0; k < NPE; k++) begin
        exp_en = (lane_q[k].size() > 0) && (lane_q[k][0][63:32] == 32'(cyc));
        check($sformatf("left_en[%0d]", k), o_left_en[k], exp_en);
        check($sformatf("right_en[%0d]", k), o_right_en[k], exp_en);
        if (exp_en) begin
          last_dat[k] = lane_q[k][0][31:0];
          void'(lane_q[k].pop_front());
        end
        check($sformatf("fmap[%0d]", k), o_fmap_f_left[k*DW +: DW], last_dat[k]);
      end
      exp_en = (done_q.size() > 0) && (done_q[0] == cyc);
      check("done", o_done, exp_en);
      if (exp_en) void'(done_q.pop_front());
    end
  end

  logic [DW-1:0] wts [NPE];
  logic [VW-1:0] w_bank;

  task automatic start_pass();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("w_ready_load", o_w_ready, 1'b1);
    check("busy_load", o_busy, 1'b1);
  endtask

  task automatic load_weights(input bit gaps);
    for (int n = 0; n < NPE; n++) begin
      if (gaps && (n % 3 == 1)) begin
        i_w_valid = 1'b0;
        @(negedge clk);
      end
      i_w_valid = 1'b1;
      i_w_data  = wts[n];
      @(negedge clk);
    end
    i_w_valid = 1'b0;
    for (int n = 0; n < NPE; n++) w_bank[n*DW +: DW] = wts[n];
    check("weight_en_at_accept", o_weight_en, 1'b0);
    check("f_ready_stream", o_f_ready, 1'b1);
    check("w_ready_stream", o_w_ready, 1'b0);
    check("weight_top", o_weight_f_top, w_bank);
    @(negedge clk);
    check("weight_en_rise", o_weight_en, 1'b1);
  endtask

  task automatic make_vec(input logic [DW-1:0] lane0, output logic [VW-1:0] v);
    v[DW-1:0] = lane0;
    for (int k = 1; k < NPE; k++) v[k*DW +: DW] = $urandom;
  endtask

  task automatic send_vec(input logic [VW-1:0] v, input bit vld, input bit last, output int t);
    check("f_ready_send", o_f_ready, 1'b1);
    i_f_valid = vld;
    i_f_data  = v;
    i_f_last  = last;
    t = cyc + 1;
    if (vld) begin
      for (int k = 0; k < NPE; k++) lane_q[k].push_back({32'(t + k), v[k*DW +: DW]});
      if (last) done_q.push_back(t + NPE);
    end
    @(negedge clk);
    i_f_valid = 1'b0;
    i_f_last  = 1'b0;
  endtask

  task automatic finish_pass(input int t_last);
    while (cyc < t_last + NPE + 1) begin
      @(negedge clk);
      check("busy_drain", o_busy, (cyc <= t_last + NPE));
      check("weight_en_drain", o_weight_en, (cyc <= t_last + NPE - 1));
      check("f_ready_drain", o_f_ready, 1'b0);
    end
    for (int k = 0; k < NPE; k++) check($sformatf("lane_left[%0d]", k), lane_q[k].size(), 0);
    check("done_left", done_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] v0, v1;
    int t;
    rst_n = 1'b0;
    i_start = 1'b0; i_w_valid = 1'b0; i_w_data = '0;
    i_f_valid = 1'b0; i_f_data = '0; i_f_last = 1'b0;
    for (int k = 0; k < NPE; k++) last_dat[k] = '0;
    wts = '{32'hBDAC8916, 32'hBD3F1A22, 32'hBD90C7E1, 32'hBC12AB34, 32'hBDE00F5D,
            32'hBD7788A9, 32'hBD1B2C3D, 32'hBDA5A5A5, 32'hBDED8EF1};
    #12;
    check("rst_busy", o_busy, 1'b0);
    check("rst_weight_en", o_weight_en, 1'b0);
    check("rst_weight_top", o_weight_f_top, '0);
    check("rst_left_en", o_left_en, '0);
    check("rst_done", o_done, 1'b0);
    check("rst_ready", {o_w_ready, o_f_ready}, 2'b00);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Weight load with gaps, two back-to-back vectors.
    start_pass();
    load_weights(1'b1);
    make_vec(32'hBD01D614, v0);
    make_vec(32'hBD5C1B3D, v1);
    send_vec(v0, 1'b1, 1'b0, t);
    send_vec(v1, 1'b1, 1'b1, t);
    finish_pass(t);

    // Bubble between two vectors; bank retained, so reload without gaps.
    start_pass();
    check("weight_top_held", o_weight_f_top, w_bank);
    load_weights(1'b0);
    make_vec(32'h3F800000, v0);
    make_vec(32'h40000000, v1);
    send_vec(v0, 1'b1, 1'b0, t);
    send_vec(v1, 1'b0, 1'b1, t);   // last without valid is ignored
    send_vec(v1, 1'b1, 1'b1, t);
    finish_pass(t);

    // Single vector pass, with stray start and weight traffic during STREAM.
    start_pass();
    load_weights(1'b0);
    i_start = 1'b1; i_w_valid = 1'b1; i_w_data = 32'hDEADBEEF;
    check("w_ready_in_stream", o_w_ready, 1'b0);
    @(negedge clk);
    i_start = 1'b0; i_w_valid = 1'b0;
    check("weight_top_stray", o_weight_f_top, w_bank);
    check("f_ready_stray", o_f_ready, 1'b1);
    make_vec(32'hC0490FDB, v0);
    send_vec(v0, 1'b1, 1'b1, t);
    finish_pass(t);

    // Reset mid-STREAM, then a fresh pass must reload new weights.
    start_pass();
    load_weights(1'b0);
    make_vec(32'h11111111, v0);
    make_vec(32'h22222222, v1);
    send_vec(v0, 1'b1, 1'b0, t);
    send_vec(v1, 1'b1, 1'b0, t);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < NPE; k++) begin
      lane_q[k].delete();
      last_dat[k] = '0;
    end
    done_q.delete();
    #1;
    check("mid_rst_left_en", o_left_en, '0);
    check("mid_rst_right_en", o_right_en, '0);
    check("mid_rst_weight_en", o_weight_en, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_weight_top", o_weight_f_top, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < NPE; n++) wts[n] = $urandom;
    start_pass();
    load_weights(1'b1);
    make_vec(32'h33333333, v0);
    send_vec(v0, 1'b1, 1'b1, t);
    finish_pass(t);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
